// File: rtl/pic_irq_priority.sv
// 8259-style IRR / mask / rotating priority resolver / ISR with the INTA pair and EOI handling.
// Latency: ir edge -> irr 1 clk, -> int_req 2 clk. No backpressure; inta_n edges and EOI pulses are always accepted.
module pic_irq_priority #(
    parameter int         NUM_IR   = 8,
    parameter logic [2:0] LP_RESET = 3'd7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_IR-1:0] i_ir,
    input  logic              i_ltim,
    input  logic [NUM_IR-1:0] i_imr,
    input  logic              i_aeoi,
    input  logic              i_init_clear,
    input  logic              i_inta_n,
    input  logic              i_eoi_pulse,
    input  logic              i_eoi_specific,
    input  logic              i_eoi_rotate,
    input  logic [2:0]        i_eoi_level,
    output logic              o_int_req,
    output logic [NUM_IR-1:0] o_irr,
    output logic [NUM_IR-1:0] o_isr,
    output logic [2:0]        o_ack_level,
    output logic              o_ack_done
);

    typedef enum logic {S_IDLE, S_ACK1} state_t;

    state_t              r_state, w_state_nxt;
    logic [NUM_IR-1:0]   r_irr, w_irr_nxt;
    logic [NUM_IR-1:0]   r_isr, w_isr_nxt;
    logic [NUM_IR-1:0]   r_ir_prev;
    logic                r_inta_prev;
    logic                r_int_req, w_int_req_nxt;
    logic [2:0]          r_ack_level, w_ack_level_nxt;
    logic                r_ack_spur, w_ack_spur_nxt;
    logic                r_ack_done, w_ack_done_nxt;
    logic [2:0]          r_lp, w_lp_nxt;

    logic [2:0]          w_hi;
    logic [NUM_IR-1:0]   w_pend;
    logic [2*NUM_IR-1:0] w_pend_dbl, w_isr_dbl;
    logic [NUM_IR-1:0]   w_pend_rot, w_isr_rot;
    logic [2:0]          w_win_pos, w_cur_pos, w_win, w_cur;
    logic                w_win_vld, w_cur_vld;
    logic                w_inta_fall;

    // Rotate so that the highest-priority level (lp+1) lands on bit 0; the
    // lowest set bit of the rotated vector is then the winner.
    assign w_hi       = r_lp + 3'd1;
    assign w_pend     = r_irr & ~i_imr;
    assign w_pend_dbl = {w_pend, w_pend} >> w_hi;
    assign w_isr_dbl  = {r_isr, r_isr} >> w_hi;
    assign w_pend_rot = w_pend_dbl[NUM_IR-1:0];
    assign w_isr_rot  = w_isr_dbl[NUM_IR-1:0];

    always_comb begin
        w_win_pos = 3'd0;
        w_win_vld = 1'b0;
        w_cur_pos = 3'd0;
        w_cur_vld = 1'b0;
        for (int j = NUM_IR - 1; j >= 0; j--) begin
            if (w_pend_rot[j]) begin
                w_win_pos = 3'(j);
                w_win_vld = 1'b1;
            end
            if (w_isr_rot[j]) begin
                w_cur_pos = 3'(j);
                w_cur_vld = 1'b1;
            end
        end
    end

    assign w_win       = w_win_pos + w_hi;
    assign w_cur       = w_cur_pos + w_hi;
    assign w_inta_fall = r_inta_prev & ~i_inta_n;

    always_comb begin
        w_state_nxt     = r_state;
        w_isr_nxt       = r_isr;
        w_lp_nxt        = r_lp;
        w_ack_level_nxt = r_ack_level;
        w_ack_spur_nxt  = r_ack_spur;
        w_ack_done_nxt  = 1'b0;
        w_irr_nxt       = i_ltim ? i_ir : (r_irr | (i_ir & ~r_ir_prev));

        if (i_eoi_pulse) begin
            if (i_eoi_specific) begin
                w_isr_nxt[i_eoi_level] = 1'b0;
                if (i_eoi_rotate)
                    w_lp_nxt = i_eoi_level;
            end else if (w_cur_vld) begin
                w_isr_nxt[w_cur] = 1'b0;
                if (i_eoi_rotate)
                    w_lp_nxt = w_cur;
            end
        end

        // INTA set is applied after the EOI clear so that it wins on the same bit.
        case (r_state)
            S_IDLE: begin
                if (w_inta_fall) begin
                    w_state_nxt = S_ACK1;
                    if (w_win_vld) begin
                        w_isr_nxt[w_win] = 1'b1;
                        w_ack_level_nxt  = w_win;
                        w_ack_spur_nxt   = 1'b0;
                        if (!i_ltim)
                            w_irr_nxt[w_win] = 1'b0;
                    end else begin
                        w_ack_level_nxt = 3'd7;
                        w_ack_spur_nxt  = 1'b1;
                    end
                end
            end
            S_ACK1: begin
                if (w_inta_fall) begin
                    w_state_nxt    = S_IDLE;
                    w_ack_done_nxt = 1'b1;
                    if (i_aeoi && !r_ack_spur)
                        w_isr_nxt[r_ack_level] = 1'b0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_int_req_nxt = (r_state == S_IDLE) && !w_inta_fall && w_win_vld &&
                        (!w_cur_vld || (w_win_pos < w_cur_pos));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_irr       <= '0;
            r_isr       <= '0;
            r_ir_prev   <= '0;
            r_inta_prev <= 1'b1;
            r_int_req   <= 1'b0;
            r_ack_level <= 3'd0;
            r_ack_spur  <= 1'b0;
            r_ack_done  <= 1'b0;
            r_lp        <= LP_RESET;
        end else if (i_init_clear) begin
            r_state     <= S_IDLE;
            r_irr       <= '0;
            r_isr       <= '0;
            r_ir_prev   <= '0;
            r_inta_prev <= 1'b1;
            r_int_req   <= 1'b0;
            r_ack_level <= 3'd0;
            r_ack_spur  <= 1'b0;
            r_ack_done  <= 1'b0;
            r_lp        <= LP_RESET;
        end else begin
            r_state     <= w_state_nxt;
            r_irr       <= w_irr_nxt;
            r_isr       <= w_isr_nxt;
            r_ir_prev   <= i_ir;
            r_inta_prev <= i_inta_n;
            r_int_req   <= w_int_req_nxt;
            r_ack_level <= w_ack_level_nxt;
            r_ack_spur  <= w_ack_spur_nxt;
            r_ack_done  <= w_ack_done_nxt;
            r_lp        <= w_lp_nxt;
        end
    end

    assign o_int_req   = r_int_req;
    assign o_irr       = r_irr;
    assign o_isr       = r_isr;
    assign o_ack_level = r_ack_level;
    assign o_ack_done  = r_ack_done;

endmodule

// File: tb/tb_pic_irq_priority.sv
// Bench for pic_irq_priority: per-cycle vector table, directed corner sequences,
// and randomized traffic checked against a rank-based reference model.
module tb_pic_irq_priority;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ir = '0;
    logic       ltim = 1'b0;
    logic [7:0] imr = '0;
    logic       aeoi = 1'b0;
    logic       init_clear = 1'b0;
    logic       inta_n = 1'b1;
    logic       eoi_pulse = 1'b0;
    logic       eoi_specific = 1'b0;
    logic       eoi_rotate = 1'b0;
    logic [2:0] eoi_level = '0;
    logic       int_req;
    logic [7:0] irr;
    logic [7:0] isr;
    logic [2:0] ack_level;
    logic       ack_done;

    int total = 0;
    int bad = 0;

    pic_irq_priority dut (
        .clk(clk), .rst_n(rst_n), .i_ir(ir), .i_ltim(ltim), .i_imr(imr),
        .i_aeoi(aeoi), .i_init_clear(init_clear), .i_inta_n(inta_n),
        .i_eoi_pulse(eoi_pulse), .i_eoi_specific(eoi_specific),
        .i_eoi_rotate(eoi_rotate), .i_eoi_level(eoi_level),
        .o_int_req(int_req), .o_irr(irr), .o_isr(isr),
        .o_ack_level(ack_level), .o_ack_done(ack_done)
    );

    always #5 clk = ~clk;

    // Reference model: priorities are ranks measured from the lowest-priority pointer.
    logic [7:0] m_irr, m_isr, m_irprev;
    logic [2:0] m_al;
    logic       m_ack1, m_spur, m_intaprev, m_int, m_done;
    int         m_lp;

    function automatic int rank_of(int lvl, int lp);
        return (lvl - lp + 7) % 8;
    endfunction

    function automatic int top(logic [7:0] v, int lp);
        int b = -1;
        for (int i = 0; i < 8; i++)
            if (v[i] && (b < 0 || rank_of(i, lp) < rank_of(b, lp)))
                b = i;
        return b;
    endfunction

    task automatic model_reset();
        m_irr = '0; m_isr = '0; m_irprev = '0; m_al = '0;
        m_ack1 = 0; m_spur = 0; m_intaprev = 1; m_int = 0; m_done = 0; m_lp = 7;
    endtask

    task automatic model_step();
        logic [7:0] pend, n_irr, n_isr;
        int w, c, lvl, n_lp;
        logic fall, req;
        if (!rst_n || init_clear) begin
            model_reset();
            return;
        end
        pend = m_irr & ~imr;
        w = top(pend, m_lp);
        c = top(m_isr, m_lp);
        fall = m_intaprev && !inta_n;
        req = (w >= 0) && (c < 0 || rank_of(w, m_lp) < rank_of(c, m_lp)) && !m_ack1 && !fall;
        n_irr = ltim ? ir : (m_irr | (ir & ~m_irprev));
        n_isr = m_isr;
        n_lp = m_lp;
        if (eoi_pulse) begin
            lvl = eoi_specific ? int'(eoi_level) : c;
            if (lvl >= 0) begin
                n_isr[lvl] = 1'b0;
                if (eoi_rotate) n_lp = lvl;
            end
        end
        m_done = 0;
        if (m_ack1 && fall) begin
            m_done = 1;
            m_ack1 = 0;
            if (aeoi && !m_spur) n_isr[m_al] = 1'b0;
        end else if (!m_ack1 && fall) begin
            m_ack1 = 1;
            if (w >= 0) begin
                n_isr[w] = 1'b1;
                m_al = 3'(w);
                m_spur = 0;
                if (!ltim) n_irr[w] = 1'b0;
            end else begin
                m_al = 3'd7;
                m_spur = 1;
            end
        end
        m_irr = n_irr; m_isr = n_isr; m_lp = n_lp;
        m_irprev = ir; m_intaprev = inta_n; m_int = req;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_cmp();
        check("model irr", irr, m_irr);
        check("model isr", isr, m_isr);
        check("model int_req", {7'b0, int_req}, {7'b0, m_int});
        check("model ack_level", {5'b0, ack_level}, {5'b0, m_al});
        check("model ack_done", {7'b0, ack_done}, {7'b0, m_done});
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        model_cmp();
    endtask

    task automatic inta_pulse();
        inta_n = 1'b0; tick();
        inta_n = 1'b1; tick();
    endtask

    task automatic do_reset();
        ir = '0; imr = '0; ltim = 0; aeoi = 0; init_clear = 0; inta_n = 1;
        eoi_pulse = 0; eoi_specific = 0; eoi_rotate = 0; eoi_level = '0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("reset irr", irr, 8'h00);
        check("reset isr", isr, 8'h00);
        check("reset int_req", {7'b0, int_req}, 8'h00);
        check("reset ack_level", {5'b0, ack_level}, 8'h00);
        check("reset ack_done", {7'b0, ack_done}, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    typedef struct {
        logic [7:0] ir;
        logic       inta_n;
        logic       eoi;
        logic [7:0] e_irr;
        logic [7:0] e_isr;
        logic       e_int;
        logic [2:0] e_al;
        logic       e_done;
    } vec_t;

    vec_t tbl [15];

    initial begin
        // Edge request followed by nesting and a non-specific EOI.
        tbl[0]  = '{8'h08, 1'b1, 1'b0, 8'h08, 8'h00, 1'b0, 3'd0, 1'b0};
        tbl[1]  = '{8'h00, 1'b1, 1'b0, 8'h08, 8'h00, 1'b1, 3'd0, 1'b0};
        tbl[2]  = '{8'h00, 1'b0, 1'b0, 8'h00, 8'h08, 1'b0, 3'd3, 1'b0};
        tbl[3]  = '{8'h00, 1'b1, 1'b0, 8'h00, 8'h08, 1'b0, 3'd3, 1'b0};
        tbl[4]  = '{8'h00, 1'b0, 1'b0, 8'h00, 8'h08, 1'b0, 3'd3, 1'b1};
        tbl[5]  = '{8'h00, 1'b1, 1'b0, 8'h00, 8'h08, 1'b0, 3'd3, 1'b0};
        tbl[6]  = '{8'h20, 1'b1, 1'b0, 8'h20, 8'h08, 1'b0, 3'd3, 1'b0};
        tbl[7]  = '{8'h20, 1'b1, 1'b0, 8'h20, 8'h08, 1'b0, 3'd3, 1'b0};
        tbl[8]  = '{8'h22, 1'b1, 1'b0, 8'h22, 8'h08, 1'b0, 3'd3, 1'b0};
        tbl[9]  = '{8'h22, 1'b1, 1'b0, 8'h22, 8'h08, 1'b1, 3'd3, 1'b0};
        tbl[10] = '{8'h22, 1'b0, 1'b0, 8'h20, 8'h0A, 1'b0, 3'd1, 1'b0};
        tbl[11] = '{8'h00, 1'b1, 1'b0, 8'h20, 8'h0A, 1'b0, 3'd1, 1'b0};
        tbl[12] = '{8'h00, 1'b0, 1'b0, 8'h20, 8'h0A, 1'b0, 3'd1, 1'b1};
        tbl[13] = '{8'h00, 1'b1, 1'b1, 8'h20, 8'h08, 1'b0, 3'd1, 1'b0};
        tbl[14] = '{8'h00, 1'b1, 1'b0, 8'h20, 8'h08, 1'b0, 3'd1, 1'b0};

        do_reset();
        for (int k = 0; k < 15; k++) begin
            ir = tbl[k].ir;
            inta_n = tbl[k].inta_n;
            eoi_pulse = tbl[k].eoi;
            tick();
            check("tbl irr", irr, tbl[k].e_irr);
            check("tbl isr", isr, tbl[k].e_isr);
            check("tbl int_req", {7'b0, int_req}, {7'b0, tbl[k].e_int});
            check("tbl ack_level", {5'b0, ack_level}, {5'b0, tbl[k].e_al});
            check("tbl ack_done", {7'b0, ack_done}, {7'b0, tbl[k].e_done});
        end
        eoi_pulse = 0;

        // Masked request and spurious acknowledge.
        do_reset();
        imr = 8'hFF;
        ir = 8'h04; tick();
        ir = 8'h00; tick();
        check("mask irr", irr, 8'h04);
        check("mask int_req", {7'b0, int_req}, 8'h00);
        inta_n = 1'b0; tick();
        check("spur ack_level", {5'b0, ack_level}, 8'h07);
        check("spur isr", isr, 8'h00);
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        check("spur ack_done", {7'b0, ack_done}, 8'h01);
        inta_n = 1'b1; tick();

        // Specific rotating EOI moves the lowest priority to level 4.
        do_reset();
        ir = 8'h10; tick();
        ir = 8'h00; tick();
        tick();
        inta_pulse(); inta_pulse();
        check("rot isr before", isr, 8'h10);
        eoi_pulse = 1; eoi_specific = 1; eoi_rotate = 1; eoi_level = 3'd4;
        tick();
        eoi_pulse = 0; eoi_specific = 0; eoi_rotate = 0;
        check("rot isr after eoi", isr, 8'h00);
        ir = 8'h50; tick();
        ir = 8'h00; tick();
        tick();
        check("rot int_req", {7'b0, int_req}, 8'h01);
        inta_n = 1'b0; tick();
        check("rot ack_level", {5'b0, ack_level}, 8'h06);
        check("rot isr", isr, 8'h40);
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        inta_n = 1'b1; tick();

        // Reset between the two INTA pulses restores lp=7 and the idle state.
        inta_n = 1'b0; tick();
        check("mid first ack", {5'b0, ack_level}, 8'h04);
        inta_n = 1'b1; tick();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mid rst isr", isr, 8'h00);
        check("mid rst irr", irr, 8'h00);
        check("mid rst int_req", {7'b0, int_req}, 8'h00);
        tick();
        rst_n = 1'b1;
        ir = 8'h50; tick();
        ir = 8'h00; tick();
        tick();
        check("post rst int_req", {7'b0, int_req}, 8'h01);
        inta_n = 1'b0; tick();
        check("post rst ack_level", {5'b0, ack_level}, 8'h04);
        check("post rst ack_done", {7'b0, ack_done}, 8'h00);
        check("post rst isr", isr, 8'h10);
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        check("post rst done", {7'b0, ack_done}, 8'h01);
        inta_n = 1'b1; tick();

        // Level-triggered with automatic EOI.
        do_reset();
        aeoi = 1; ltim = 1; ir = 8'h01;
        tick();
        check("lvl irr", irr, 8'h01);
        tick();
        check("lvl int_req", {7'b0, int_req}, 8'h01);
        inta_n = 1'b0; tick();
        check("lvl isr ack1", isr, 8'h01);
        check("lvl irr ack1", irr, 8'h01);
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        check("aeoi done", {7'b0, ack_done}, 8'h01);
        check("aeoi isr", isr, 8'h00);
        check("aeoi irr", irr, 8'h01);
        check("aeoi int_req low", {7'b0, int_req}, 8'h00);
        inta_n = 1'b1; tick();
        check("aeoi int_req again", {7'b0, int_req}, 8'h01);
        init_clear = 1'b1; tick();
        init_clear = 1'b0;
        check("init_clear irr", irr, 8'h00);
        check("init_clear int_req", {7'b0, int_req}, 8'h00);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 3) == 0) ir = 8'($urandom);
            if ($urandom_range(0, 15) == 0) imr = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 199) == 0) ltim = ~ltim;
            if ($urandom_range(0, 99) == 0) aeoi = ~aeoi;
            inta_n = ($urandom_range(0, 2) != 0);
            eoi_pulse = ($urandom_range(0, 7) == 0);
            eoi_specific = 1'($urandom);
            eoi_rotate = 1'($urandom);
            eoi_level = 3'($urandom);
            init_clear = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                model_cmp();
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end
        init_clear = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
